// File: rtl/gray_ptr_rx_if.sv
// rtl/gray_ptr_rx_if.sv - pointer-crossing receive bundle: remote Gray pointer in, decoded pointer/occupancy/errors out
interface gray_ptr_rx_if #(
    parameter int WIDTH_D   = 5,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH_D-1:0]   gray_in;
    logic [WIDTH_D-1:0]   local_bin;
    logic                 clr_err;
    logic [WIDTH_D-1:0]   bin_out;
    logic [WIDTH_D-1:0]   level_out;
    logic                 bin_valid;
    logic                 err_pulse;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output gray_in, local_bin, clr_err,
        input  bin_out, level_out, bin_valid, err_pulse, err_sticky, err_cnt
    );

    modport slave (
        input  gray_in, local_bin, clr_err,
        output bin_out, level_out, bin_valid, err_pulse, err_sticky, err_cnt
    );
endinterface

// File: rtl/gray_ptr_rx.sv
// rtl/gray_ptr_rx.sv - synchronise a far-domain Gray pointer, decode it, compute occupancy, police the Gray rule
module gray_ptr_rx #(
    parameter int WIDTH_D     = 5,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    gray_ptr_rx_if.slave   bus
);
    localparam logic [WIDTH_D-1:0]   PTR_ONE   = WIDTH_D'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_ONE   = ERR_CNT_W'(1);
    localparam logic [2:0]           WARM_DONE = 3'(SYNC_STAGES);

    logic [WIDTH_D-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH_D-1:0]   sync_d [SYNC_STAGES];
    logic [WIDTH_D-1:0]   gray_prev_q, gray_prev_d;
    logic [WIDTH_D-1:0]   bin_q, bin_d;
    logic [WIDTH_D-1:0]   level_q, level_d;
    logic                 valid_q, valid_d;
    logic                 pulse_q, pulse_d;
    logic                 sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]           warm_q, warm_d;

    logic [WIDTH_D-1:0]   g_s;
    logic [WIDTH_D-1:0]   b;
    logic [WIDTH_D-1:0]   diff;
    logic                 viol;

    assign g_s = sync_q[SYNC_STAGES-1];

    // Binary bit i is the XOR of every Gray bit at or above i.
    always_comb begin
        b = '0;
        for (int i = 0; i < WIDTH_D; i++) begin
            b[i] = ^(g_s >> i);
        end
    end

    always_comb begin
        sync_d[0] = bus.gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        // More than one bit set iff clearing the lowest set bit leaves something.
        diff = g_s ^ gray_prev_q;
        viol = valid_q && ((diff & (diff - PTR_ONE)) != '0);

        gray_prev_d = g_s;
        bin_d       = b;
        level_d     = b - bus.local_bin;
        warm_d      = (warm_q == WARM_DONE) ? warm_q : warm_q + 3'd1;
        valid_d     = valid_q | (warm_q == WARM_DONE);
        pulse_d     = viol;

        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (viol) begin
            sticky_d = 1'b1;
            if (bus.clr_err) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (bus.clr_err) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            gray_prev_q <= '0;
            bin_q       <= '0;
            level_q     <= '0;
            valid_q     <= 1'b0;
            pulse_q     <= 1'b0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            warm_q      <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            gray_prev_q <= gray_prev_d;
            bin_q       <= bin_d;
            level_q     <= level_d;
            valid_q     <= valid_d;
            pulse_q     <= pulse_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            warm_q      <= warm_d;
        end
    end

    assign bus.bin_out    = bin_q;
    assign bus.level_out  = level_q;
    assign bus.bin_valid  = valid_q;
    assign bus.err_pulse  = pulse_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = cnt_q;
endmodule
